// File: rtl/div_ctrl_pkg.sv
// div_ctrl shared types: FSM encoding, datapath widths, sign helpers.
// Shared by div_ctrl and div_radix2_step.
package div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] mag(
    input logic [DIV_WIDTH-1:0] v,
    input logic                 sgn
  );
    return (sgn && v[DIV_WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] neg_if(
    input logic [DIV_WIDTH-1:0] v,
    input logic                 neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One restoring radix-2 division step, purely combinational.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module div_radix2_step
  import div_ctrl_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] i_rem,
  input  logic [DIV_WIDTH-1:0] i_quo,
  input  logic [DIV_WIDTH-1:0] i_dvs,
  output logic [DIV_WIDTH-1:0] o_rem,
  output logic [DIV_WIDTH-1:0] o_quo
);

  logic [DIV_WIDTH:0]   w_trial;
  logic [DIV_WIDTH+1:0] w_diff;
  logic                 w_neg;

  assign w_trial = {i_rem, i_quo[DIV_WIDTH-1]};
  assign w_diff  = {1'b0, w_trial} - {2'b00, i_dvs};

  // rem < divisor holds, so a set bit 32 can only come from a borrow
  assign w_neg = |w_diff[DIV_WIDTH+1:DIV_WIDTH];

  assign o_rem = w_neg ? w_trial[DIV_WIDTH-1:0]
                       : w_diff[DIV_WIDTH-1:0];
  assign o_quo = {i_quo[DIV_WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit: IDLE->RUN(32)->FIX->DONE with EX stall.
// DIV_ZERO_FAST_EN: zero divisor bypasses RUN and finishes in 2 cycles.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [DIV_WIDTH-1:0] opa,
  input  logic [DIV_WIDTH-1:0] opb,
  input  logic                 flush,
  input  logic                 ext_stall,
  output logic                 stall_o,
  output logic                 busy,
  output logic                 result_valid,
  output logic [DIV_WIDTH-1:0] hi_o,
  output logic [DIV_WIDTH-1:0] lo_o
);

  div_state_e           r_state;
  div_state_e           w_next;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_rem;
  logic [DIV_WIDTH-1:0] r_quo;
  logic [DIV_WIDTH-1:0] r_dvs;
  logic                 r_qneg;
  logic                 r_rneg;
  logic [DIV_WIDTH-1:0] r_hi;
  logic [DIV_WIDTH-1:0] r_lo;
  logic [DIV_WIDTH-1:0] w_rem;
  logic [DIV_WIDTH-1:0] w_quo;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_zero;
`ifdef DIV_ZERO_FAST_EN
  logic                 r_zero;
`endif

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_last   = (r_cnt == DIV_CNT_W'(DIV_WIDTH - 1));
  assign w_zero   = (opb == '0);

  div_radix2_step u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem),
    .o_quo (w_quo)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_FAST_EN
            w_next = w_zero ? S_FIX : S_RUN;
`else
            w_next = S_RUN;
`endif
          end
        end
        S_RUN:  if (w_last) w_next = S_FIX;
        S_FIX:  w_next = S_DONE;
        S_DONE: if (!ext_stall) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= mag(opa, signed_div);
      r_dvs  <= mag(opb, signed_div);
      r_qneg <= signed_div & (opa[DIV_WIDTH-1] ^ opb[DIV_WIDTH-1]);
      r_rneg <= signed_div & opa[DIV_WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
      // raw dividend parked in quo; FIX hands it out as the remainder
      if (w_zero) r_quo <= opa;
`endif
    end else if (r_state == S_RUN && !flush) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_rem;
      r_quo <= w_quo;
    end
  end

`ifdef DIV_ZERO_FAST_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_zero <= 1'b0;
    else if (w_accept) r_zero <= w_zero;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX && !flush) begin
`ifdef DIV_ZERO_FAST_EN
      if (r_zero) begin
        r_hi <= r_quo;
        r_lo <= '1;
      end else begin
        r_hi <= neg_if(r_rem, r_rneg);
        r_lo <= neg_if(r_quo, r_qneg);
      end
`else
      r_hi <= neg_if(r_rem, r_rneg);
      r_lo <= neg_if(r_quo, r_qneg);
`endif
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE) && !flush;
  assign stall_o      = (r_state == S_IDLE) ? start
                      : (r_state == S_RUN) || (r_state == S_FIX);
  assign hi_o         = r_hi;
  assign lo_o         = r_lo;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: scoreboard of expected {hi,lo}.
// Latency of the zero-divisor case follows DIV_ZERO_FAST_EN.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        ext_stall;
  logic        stall_o;
  logic        busy;
  logic        result_valid;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  div_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .opa          (opa),
    .opb          (opb),
    .flush        (flush),
    .ext_stall    (ext_stall),
    .stall_o      (stall_o),
    .busy         (busy),
    .result_valid (result_valid),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // truncating division reference: returns {remainder, quotient}
  function automatic logic [63:0] model(
    input bit sd, input logic [31:0] a, input logic [31:0] b
  );
    logic [31:0] ma, mb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    ma = (sd && a[31]) ? -a : a;
    mb = (sd && b[31]) ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (sd && (a[31] ^ b[31])) q = -q;
    if (sd && a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic issue(
    input bit sd, input logic [31:0] a, input logic [31:0] b,
    input logic [63:0] exp
  );
    @(negedge clk);
    signed_div = sd;
    opa = a;
    opb = b;
    start = 1'b1;
    sb.push_back(exp);
  endtask

  task automatic wait_rv(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (result_valid) break;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 0; signed_div = 0; opa = 0; opb = 0;
    flush = 0; ext_stall = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, result_valid, stall_o, hi_o, lo_o} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b rv=%b st=%b hi=%h lo=%h want all 0",
               busy, result_valid, stall_o, hi_o, lo_o);
    end
    resetn = 1'b1;
  endtask

  task automatic test_divu_latency;
    int bad = 0;
    int rvc = -1;
    logic [63:0] exp;
    issue(0, 32'd100, 32'd7, {32'd2, 32'd14});
    #1;
    vectors++;
    if (stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_accept: got %b want 1", stall_o);
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 33 && (stall_o !== 1'b1 || result_valid !== 1'b0)) bad++;
      if (result_valid === 1'b1) begin
        rvc = c;
        break;
      end
    end
    exp = sb.pop_front();
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL divu_stall_run: %0d bad cycles, want 0", bad);
    end
    vectors++;
    if (rvc != 34) begin
      miscompares++;
      $display("FAIL divu_latency: got %0d want 34", rvc);
    end
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL divu_stall_done: got %b want 0", stall_o);
    end
    vectors++;
    if ({hi_o, lo_o} !== exp) begin
      miscompares++;
      $display("FAIL divu_100_7: got hi=%h lo=%h want hi=%h lo=%h",
               hi_o, lo_o, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_signed;
    logic [31:0] a[5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7,
                          32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] b[5] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                          32'hFFFF_FFFE, 32'd2};
    bit          s[5] = '{1, 1, 1, 1, 0};
    logic [63:0] e[5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD},
                          {32'h0, 32'h8000_0000},
                          {32'h1, 32'hFFFF_FFFD},
                          {32'hFFFF_FFFF, 32'h3},
                          {32'h1, 32'h7FFF_FFFF}};
    int lat;
    logic [63:0] exp;
    for (int i = 0; i < 5; i++) begin
      issue(s[i], a[i], b[i], e[i]);
      wait_rv(lat);
      exp = sb.pop_front();
      vectors++;
      if (lat != 34 || {hi_o, lo_o} !== exp) begin
        miscompares++;
        $display("FAIL signed_%0d: got lat=%0d hi=%h lo=%h want lat=34 hi=%h lo=%h",
                 i, lat, hi_o, lo_o, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_flush;
    bit seen = 0;
    issue(0, 32'd1000, 32'd3, model(0, 32'd1000, 32'd3));
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(sb.pop_back());
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_run: got busy=%b rv=%b want 0 0", busy, result_valid);
    end
    repeat (40) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL flush_no_result: got rv=1 after flush want 0");
    end
    @(negedge clk);
    opa = 32'd9; opb = 32'd3; signed_div = 0;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_ext_stall;
    int lat;
    int bad = 0;
    logic [63:0] exp;
    issue(0, 32'd50, 32'd6, {32'd2, 32'd8});
    wait_rv(lat);
    exp = sb.pop_front();
    vectors++;
    if (lat != 34 || {hi_o, lo_o} !== exp) begin
      miscompares++;
      $display("FAIL estall_result: got lat=%0d hi=%h lo=%h want lat=34 hi=%h lo=%h",
               lat, hi_o, lo_o, exp[63:32], exp[31:0]);
    end
    ext_stall = 1'b1;
    start = 1'b1;
    opa = 32'd9; opb = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (result_valid !== 1'b1 || {hi_o, lo_o} !== exp) bad++;
      if (k == 5) begin
        ext_stall = 1'b0;
        start = 1'b0;
      end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL estall_hold: %0d unstable cycles, want 0", bad);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL estall_release: got busy=%b rv=%b want 0 0", busy, result_valid);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic [63:0] exp;
    issue(0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    wait_rv(lat);
    exp = sb.pop_front();
    vectors++;
    if (lat != ZLAT || {hi_o, lo_o} !== exp) begin
      miscompares++;
      $display("FAIL divzero: got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
               lat, hi_o, lo_o, ZLAT, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [63:0] exp;
    issue(0, 32'd12345, 32'd67, {32'd17, 32'd184});
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    void'(sb.pop_back());
    vectors++;
    if ({busy, result_valid, stall_o, hi_o, lo_o} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b rv=%b st=%b hi=%h lo=%h want all 0",
               busy, result_valid, stall_o, hi_o, lo_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    issue(0, 32'd12345, 32'd67, {32'd17, 32'd184});
    wait_rv(lat);
    exp = sb.pop_front();
    vectors++;
    if (lat != 34 || {hi_o, lo_o} !== exp) begin
      miscompares++;
      $display("FAIL reset_recover: got lat=%0d hi=%h lo=%h want lat=34 hi=%h lo=%h",
               lat, hi_o, lo_o, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit sd;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 10; i++) begin
      sd = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 15)) : $urandom;
      if (b == 0) b = 32'd1;
      issue(sd, a, b, model(sd, a, b));
      wait_rv(lat);
      exp = sb.pop_front();
      vectors++;
      if (lat != 34 || {hi_o, lo_o} !== exp) begin
        miscompares++;
        $display("FAIL b2b_%0d %s %h/%h: got lat=%0d hi=%h lo=%h want lat=34 hi=%h lo=%h",
                 i, sd ? "DIV" : "DIVU", a, b, lat, hi_o, lo_o,
                 exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divu_latency();
    test_signed();
    test_flush();
    test_ext_stall();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
